// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle LEGv8 main FSM and its datapath.
// The master side is the controller; the slave side is the datapath/memory.
interface multicycle_ctrl_if;
    logic [10:0] op;
    logic        zero;
    logic        memready;
    logic        irwrite;
    logic        pcwrite;
    logic        iord;
    logic        memread;
    logic        memwrite;
    logic        regwrite;
    logic        memtoreg;
    logic        reg2loc;
    logic [1:0]  alusrca;
    logic [1:0]  alusrcb;
    logic [1:0]  aluop;
    logic        pcsrc;
    logic        illegal;

    modport master (
        input  op, zero, memready,
        output irwrite, pcwrite, iord, memread, memwrite, regwrite, memtoreg,
               reg2loc, alusrca, alusrcb, aluop, pcsrc, illegal
    );

    modport slave (
        output op, zero, memready,
        input  irwrite, pcwrite, iord, memread, memwrite, regwrite, memtoreg,
               reg2loc, alusrca, alusrcb, aluop, pcsrc, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle LEGv8 datapath: fetch/decode/execute/
// memory/writeback sequencing with stalls on the memory ready handshake.
module multicycle_ctrl (
    input  logic                clk,
    input  logic                reset,
    multicycle_ctrl_if.master   bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, ALUWB, CBZ, UNCOND
    } state_t;

    state_t state;

    logic is_ldur, is_stur, is_cbz, is_b, is_rtype;
    assign is_ldur  = (bus.op == 11'b11111000010);
    assign is_stur  = (bus.op == 11'b11111000000);
    assign is_cbz   = (bus.op[10:3] == 8'b10110100);
    assign is_b     = (bus.op[10:5] == 6'b000101);
    assign is_rtype = (bus.op == 11'b10001011000) || (bus.op == 11'b11001011000) ||
                      (bus.op == 11'b10001010000) || (bus.op == 11'b10101010000);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:  if (bus.memready) state <= DECODE;
                DECODE: begin
                    if (is_ldur || is_stur) state <= MEMADR;
                    else if (is_rtype)      state <= EXECR;
                    else if (is_cbz)        state <= CBZ;
                    else if (is_b)          state <= UNCOND;
                    else                    state <= FETCH;
                end
                MEMADR: state <= is_ldur ? MEMRD : MEMWR;
                MEMRD:  if (bus.memready) state <= MEMWB;
                MEMWR:  if (bus.memready) state <= FETCH;
                EXECR:  state <= ALUWB;
                default: state <= FETCH;
            endcase
        end
    end

    logic       irwrite, pcwrite, iord, memread, memwrite, regwrite;
    logic       memtoreg, reg2loc, pcsrc, illegal;
    logic [1:0] alusrca, alusrcb, aluop;

    // Reset gates the decode so a store or PC update is killed in the very
    // cycle reset rises, not one edge later.
    always_comb begin
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        iord     = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        memtoreg = 1'b0;
        reg2loc  = 1'b0;
        alusrca  = 2'b00;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        pcsrc    = 1'b0;
        illegal  = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = bus.memready;
                    pcwrite = bus.memready;
                end
                DECODE: begin
                    alusrca = 2'b10;
                    alusrcb = 2'b11;
                    illegal = !(is_ldur || is_stur || is_rtype || is_cbz || is_b);
                end
                MEMADR: begin
                    alusrca = 2'b01;
                    alusrcb = 2'b10;
                end
                MEMRD: begin
                    iord    = 1'b1;
                    memread = 1'b1;
                end
                MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                    reg2loc  = 1'b1;
                end
                EXECR: begin
                    alusrca = 2'b01;
                    aluop   = 2'b10;
                end
                ALUWB: regwrite = 1'b1;
                CBZ: begin
                    alusrca = 2'b01;
                    aluop   = 2'b01;
                    reg2loc = 1'b1;
                    pcsrc   = 1'b1;
                    pcwrite = bus.zero;
                end
                UNCOND: begin
                    pcsrc   = 1'b1;
                    pcwrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.irwrite  = irwrite;
    assign bus.pcwrite  = pcwrite;
    assign bus.iord     = iord;
    assign bus.memread  = memread;
    assign bus.memwrite = memwrite;
    assign bus.regwrite = regwrite;
    assign bus.memtoreg = memtoreg;
    assign bus.reg2loc  = reg2loc;
    assign bus.alusrca  = alusrca;
    assign bus.alusrcb  = alusrcb;
    assign bus.aluop    = aluop;
    assign bus.pcsrc    = pcsrc;
    assign bus.illegal  = illegal;
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle LEGv8 datapath. Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath enables and muxes. It sits directly upstream of the ALU control decoder and feeds it `aluop` every cycle. The decoder turns `aluop` plus the funct field into `alucontrol`. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; forces FSM to FETCH and all outputs low.
- `op`  in  11  instruction bits [31:21], taken from the instruction register.
- `zero`  in  1  ALU zero flag, valid in the CBZ state.
- `memready`  in  1  memory completes the current read/write this cycle.
- `irwrite`  out  1  load instruction register.
- `pcwrite`  out  1  load PC.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memread`  out  1  memory read request.
- `memwrite`  out  1  memory write request.
- `regwrite`  out  1  register file write.
- `memtoreg`  out  1  writeback data select: 0 = ALUOut, 1 = memory data register.
- `reg2loc`  out  1  read port 2 address select: 0 = Rm, 1 = Rt.
- `alusrca`  out  2  ALU A select: 00 = PC, 01 = register A, 10 = oldPC (the address of the current instruction).
- `alusrcb`  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended D-format immediate, 11 = branch offset shifted left by 2.
- `aluop`  out  2  to ALU control decoder: 00 = add, 01 = pass B, 10 = R-type by funct.
- `pcsrc`  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- `illegal`  out  1  one-cycle flag for an unrecognised opcode.

## Operation
- Opcode classes:
  - LDUR: `op` = 11111000010.
  - STUR: `op` = 11111000000.
  - CBZ: `op[10:3]` = 10110100.
  - B: `op[10:5]` = 000101.
  - R-type: `op` ∈ {10001011000, 11001011000, 10001010000, 10101010000}.
  - Anything else is illegal.
- Outputs are Moore, except `irwrite`/`pcwrite` in FETCH, `pcwrite` in CBZ, and `illegal`. Every output not listed for a state is 0; `aluop` defaults to 00.
- **FETCH**: `memread`=1, `iord`=0, `alusrca`=00, `alusrcb`=01, `pcsrc`=0.
  - `irwrite`=`pcwrite`=`memready`.
  - Stay in FETCH while `memready`=0; go to DECODE when `memready`=1.
- **DECODE**: `alusrca`=10, `alusrcb`=11, `aluop`=00. This computes the branch target into ALUOut.
  - LDUR/STUR → MEMADR; R-type → EXECR; CBZ → CBZ; B → UNCOND.
  - Illegal: `illegal`=1, next state FETCH.
- **MEMADR**: `alusrca`=01, `alusrcb`=10, `aluop`=00. LDUR → MEMRD; STUR → MEMWR.
- **MEMRD**: `iord`=1, `memread`=1. Wait for `memready`, then → MEMWB.
- **MEMWB**: `regwrite`=1, `memtoreg`=1 → FETCH.
- **MEMWR**: `iord`=1, `memwrite`=1, `reg2loc`=1. Wait for `memready`, then → FETCH.
- **EXECR**: `alusrca`=01, `alusrcb`=00, `aluop`=10 → ALUWB.
- **ALUWB**: `regwrite`=1, `memtoreg`=0 → FETCH.
- **CBZ**: `alusrca`=01, `alusrcb`=00, `aluop`=01, `reg2loc`=1, `pcsrc`=1, `pcwrite`=`zero` → FETCH.
- **UNCOND**: `pcsrc`=1, `pcwrite`=1 → FETCH.
- `op` is sampled only in DECODE and MEMADR; it is held stable by the instruction register in all other states.

## Timing
- State register updates on the rising edge of `clk`. Reset is asynchronous to FETCH.
- While `reset`=1, all outputs are combinationally forced to 0, including `memread` in FETCH.
- First fetch request occurs in the first cycle after `reset` deasserts.
- Latency with `memready` tied high:
  - R-type: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - CBZ: 3 cycles.
  - B: 3 cycles.
  - Illegal: 2 cycles.
- Each memory wait cycle adds 1 cycle in FETCH, MEMRD or MEMWR.
- Memory request signals (`memread`/`memwrite`/`iord`) are held constant until the `memready` cycle. They drop the cycle after.
- `memready` outside FETCH/MEMRD/MEMWR is ignored.
- `zero` is ignored outside CBZ.
- Reset asserted mid-instruction (including while stalled in MEMWR) aborts immediately: no `regwrite`/`memwrite`/`pcwrite` in that cycle or after.

## Test plan
- **Reset**: hold `reset`=1 for 3 cycles, then release with `memready`=1.
  - During reset, all outputs are 0.
  - Next cycle: `memread`=1, `irwrite`=1, `pcwrite`=1, `alusrcb`=01.
- **ADD**: `op`=10001011000, `memready`=1.
  - State sequence FETCH→DECODE→EXECR→ALUWB→FETCH.
  - `aluop`=10 only in EXECR; `regwrite`=1 only in ALUWB.
- **LDUR with stall**: `op`=11111000010, `memready` low for 2 cycles in MEMRD.
  - `iord`=1 and `memread`=1 held for 3 cycles.
  - Then MEMWB with `memtoreg`=1, `regwrite`=1; 7 cycles total.
- **CBZ**: `op`=10110100xxx, once with `zero`=1 and once with `zero`=0.
  - `aluop`=01 and `reg2loc`=1 in CBZ.
  - `pcwrite`=1 only when `zero`=1; each run is 3 cycles.
- **Illegal opcode**: `op`=00000000000.
  - `illegal`=1 for exactly one cycle, in DECODE.
  - Returns to FETCH; no `regwrite`/`memwrite`.
- **Reset mid-store**: assert `reset` during MEMWR with `memready`=0.
  - `memwrite` drops to 0 in the same cycle.
  - After release, FSM restarts at FETCH.
